// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4:1 mux one channel at a time, captures each channel into
// a 4-bit word and returns it to the consumer with a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_y,
    output logic       sel_s0,
    output logic       sel_s1,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic [7:0] scan_count
);

    // state  | meaning
    // IDLE   | no scan, selects parked at channel 0
    // SETTLE | select just changed, waiting SETTLE cycles for the mux to settle
    // SAMPLE | one cycle, mux_y captured into dout[idx]
    // HOLD   | word complete, waiting for dout_ready
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    // With SETTLE = 0 the SETTLE state is skipped entirely.
    localparam logic [2:0] SETTLE_INIT = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
    localparam state_t     CHAN_ENTRY  = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  dout_q, dout_d;
    logic [7:0]  count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 3'd0;
            dout_q  <= 4'd0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        count_d = count_q;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = 3'd0;
            dout_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort in IDLE blocks a simultaneous start
                    if (start && !abort) begin
                        state_d = CHAN_ENTRY;
                        idx_d   = 2'd0;
                        cnt_d   = SETTLE_INIT;
                        dout_d  = 4'd0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 3'd0) begin
                        state_d = S_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                S_SAMPLE: begin
                    dout_d[idx_q] = mux_y;
                    if (idx_q == 2'd3) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = CHAN_ENTRY;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = SETTLE_INIT;
                    end
                end
                S_HOLD: begin
                    if (dout_ready) begin
                        count_d = count_q + 8'd1;
                        idx_d   = 2'd0;
                        if (start) begin
                            state_d = CHAN_ENTRY;
                            cnt_d   = SETTLE_INIT;
                            dout_d  = 4'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sel_s0     = idx_q[1];
    assign sel_s1     = idx_q[0];
    assign dout       = dout_q;
    assign dout_valid = (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign scan_count = count_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: one instance with SETTLE=1, one with SETTLE=0.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // SETTLE = 1 instance
    logic       start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
    logic [3:0] word1  = 4'd0;
    logic       mux_y1, sel_s0_1, sel_s1_1, dout_valid1, busy1;
    logic [3:0] dout1;
    logic [7:0] scan_count1;

    // SETTLE = 0 instance
    logic       start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b0;
    logic [3:0] word0  = 4'd0;
    logic       mux_y0, sel_s0_0, sel_s1_0, dout_valid0, busy0;
    logic [3:0] dout0;
    logic [7:0] scan_count0;

    // mux model: channel n returns bit n of the word
    assign mux_y1 = word1[{sel_s0_1, sel_s1_1}];
    assign mux_y0 = word0[{sel_s0_0, sel_s1_0}];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .mux_y(mux_y1),
        .sel_s0(sel_s0_1), .sel_s1(sel_s1_1), .dout(dout1), .dout_valid(dout_valid1),
        .dout_ready(ready1), .busy(busy1), .scan_count(scan_count1)
    );

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .mux_y(mux_y0),
        .sel_s0(sel_s0_0), .sel_s1(sel_s1_0), .dout(dout0), .dout_valid(dout_valid0),
        .dout_ready(ready0), .busy(busy0), .scan_count(scan_count0)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] sb1[$];
    logic [3:0] sb0[$];
    logic [7:0] exp_cnt1 = 8'd0;
    logic [7:0] exp_cnt0 = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop1(output logic [3:0] w);
        if (sb1.size() > 0) w = sb1.pop_front();
        else w = 4'hx;
    endtask

    // Full scan on the SETTLE=1 instance; ready held low for hold_wait cycles in HOLD.
    task automatic run_scan1(input logic [3:0] w, input int hold_wait);
        int c;
        logic [3:0] e;
        word1  = w;
        start1 = 1'b1;
        sb1.push_back(w);
        tick();
        start1 = 1'b0;
        c = 1;
        while (!dout_valid1 && c < 60) begin
            if (c <= 8) check("sel1", {30'd0, sel_s0_1, sel_s1_1}, (c - 1) / 2);
            if (c == 1) check("clr1", dout1, 0);
            if (c == 5) check("part1", dout1, {28'd0, 2'b00, w[1:0]});
            tick();
            c++;
        end
        check("lat1", c, 9);
        for (int i = 0; i < hold_wait; i++) begin
            word1  = ~word1;
            start1 = ~start1;
            tick();
            check("hold_dout1", dout1, w);
            check("hold_valid1", dout_valid1, 1);
            check("hold_sel1", {30'd0, sel_s0_1, sel_s1_1}, 3);
            check("hold_cnt1", scan_count1, exp_cnt1);
        end
        start1 = 1'b0;
        ready1 = 1'b1;
        pop1(e);
        check("dout1", dout1, e);
        tick();
        ready1   = 1'b0;
        exp_cnt1 = exp_cnt1 + 8'd1;
        check("cnt1", scan_count1, exp_cnt1);
        check("idle_busy1", busy1, 0);
        check("idle_sel1", {30'd0, sel_s0_1, sel_s1_1}, 0);
        check("idle_valid1", dout_valid1, 0);
    endtask

    initial begin
        int c, last, k;
        logic [3:0] e;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy1", busy1, 0);
        check("rst_dout1", dout1, 0);
        check("rst_valid1", dout_valid1, 0);
        check("rst_sel1", {30'd0, sel_s0_1, sel_s1_1}, 0);
        check("rst_cnt1", scan_count1, 0);
        check("rst_busy0", busy0, 0);

        // basic scan plus 10 cycles of back-pressure in HOLD
        run_scan1(4'b1010, 10);

        // abort while SAMPLE idx=2 is active
        word1  = 4'b0110;
        start1 = 1'b1;
        sb1.push_back(word1);
        tick();
        start1 = 1'b0;
        for (int i = 1; i < 6; i++) tick();
        check("abt_sel", {30'd0, sel_s0_1, sel_s1_1}, 2);
        check("abt_busy_pre", busy1, 1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        void'(sb1.pop_back());
        check("abt_busy", busy1, 0);
        check("abt_dout", dout1, 0);
        check("abt_sel0", {30'd0, sel_s0_1, sel_s1_1}, 0);
        check("abt_valid", dout_valid1, 0);
        check("abt_cnt", scan_count1, exp_cnt1);
        abort1 = 1'b1;
        start1 = 1'b1;
        tick();
        abort1 = 1'b0;
        start1 = 1'b0;
        check("abt_idle1", busy1, 0);
        tick();
        check("abt_idle2", busy1, 0);

        run_scan1(4'b0001, 0);
        run_scan1(4'b1111, 0);
        run_scan1(4'b0100, 0);
        run_scan1(4'b1000, 0);
        check("cnt5", scan_count1, 5);

        // reset during SETTLE
        start1 = 1'b1;
        word1  = 4'b1111;
        sb1.push_back(word1);
        tick();
        start1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb1.delete();
        exp_cnt1 = 8'd0;
        check("mrst_busy", busy1, 0);
        check("mrst_dout", dout1, 0);
        check("mrst_valid", dout_valid1, 0);
        check("mrst_sel", {30'd0, sel_s0_1, sel_s1_1}, 0);
        check("mrst_cnt", scan_count1, 0);
        run_scan1(4'b0011, 0);

        // drive scan_count to 255 and then wrap
        for (int i = 0; i < 254; i++) run_scan1(4'($urandom_range(0, 15)), 0);
        check("cnt255", scan_count1, 255);
        run_scan1(4'b0101, 0);
        check("wrap", scan_count1, 0);

        // SETTLE=0: start held, ready tied high, back-to-back scans
        word0  = 4'b1010;
        start0 = 1'b1;
        ready0 = 1'b1;
        sb0.push_back(word0);
        c = 0;
        last = 0;
        k = 0;
        while (k < 4 && c < 200) begin
            tick();
            c++;
            if (dout_valid0) begin
                check("period0", c - last, 5);
                last = c;
                if (sb0.size() > 0) e = sb0.pop_front();
                else e = 4'hx;
                check("dout0", dout0, e);
                check("cnt0", scan_count0, exp_cnt0);
                exp_cnt0 = exp_cnt0 + 8'd1;
                if (k == 3) begin
                    start0 = 1'b0;
                end else begin
                    word0 = word0 + 4'd3;
                    sb0.push_back(word0);
                end
                k++;
            end
        end
        check("done0", k, 4);
        tick();
        ready0 = 1'b0;
        check("end_cnt0", scan_count0, exp_cnt0);
        check("end_busy0", busy0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, legal 0..7: wait cycles after each select change before mux output is sampled.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a 4-channel scan; accepted only as defined in REQ-011/REQ-017.
REQ-005 abort  input  1  terminate any scan in progress.
REQ-006 mux_y  input  1  output of the downstream 4:1 mux under scan.
REQ-007 sel_s0  output  1  mux select, MSB of channel index.
REQ-008 sel_s1  output  1  mux select, LSB of channel index.
REQ-009 dout  output  4  captured word; dout[n] = mux_y sampled with channel n selected.
REQ-010 dout_valid, dout_ready (output 1, input 1)  result handshake; busy (output 1) high whenever state is not IDLE; scan_count (output 8) completed-scan counter.

Function
REQ-011 The FSM SHALL have states IDLE, SETTLE, SAMPLE, HOLD; start sampled high in IDLE moves to SETTLE (SETTLE>0) or SAMPLE (SETTLE=0) with channel index idx=0.
REQ-012 Channel index idx (2 bits) SHALL drive selects as sel_s0=idx[1], sel_s1=idx[0] (channel n = 2*s0 + s1), registered, changing only on entry to SETTLE/SAMPLE for a new channel.
REQ-013 SETTLE SHALL last exactly SETTLE cycles via a down-counter, then move to SAMPLE.
REQ-014 SAMPLE SHALL last one cycle: register mux_y into dout[idx]; if idx=3 go to HOLD, else idx+1 and go to SETTLE (or SAMPLE again if SETTLE=0).
REQ-015 dout_valid SHALL be high exactly while in HOLD; first high 4*(SETTLE+1)+1 cycles after the cycle in which start was accepted.
REQ-016 In HOLD, dout and dout_valid SHALL hold stable until dout_ready sampled high; then scan_count increments (8-bit, wraps 255->0) and FSM leaves HOLD.
REQ-017 HOLD with dout_ready=1 and start=1 SHALL begin a new scan directly (back-to-back, no IDLE cycle); with start=0 go to IDLE.
REQ-018 start sampled in SETTLE or SAMPLE, or in HOLD without dout_ready, SHALL be ignored (not queued).
REQ-019 abort high in any non-IDLE state SHALL force IDLE next cycle: dout_valid=0, idx=0, selects 00, dout cleared to 0, scan_count unchanged.
REQ-020 abort SHALL dominate start and dout_ready in the same cycle; abort in IDLE has no effect and blocks start.
REQ-021 dout bits not yet sampled in the current scan SHALL read 0 (dout cleared on scan start).
REQ-022 In IDLE, selects SHALL be 00 and busy=0.

Reset
REQ-023 rst high SHALL force next cycle: state IDLE, idx 0, sel_s0=0, sel_s1=0, dout=0, dout_valid=0, busy=0, scan_count=0, settle counter 0.
REQ-024 rst SHALL dominate abort, start and dout_ready; rst mid-scan SHALL discard the partial word.

Verification
REQ-025 SETTLE=1, mux inputs model word 4'b1010 (channel n returns bit n), start pulse at cycle 0 -> selects step 00,01,10,11; dout_valid at cycle 9; dout=4'b1010.
REQ-026 SETTLE=0, same stimulus, dout_ready tied high, start held high -> dout_valid at cycle 5, back-to-back scans every 5 cycles, scan_count increments each scan.
REQ-027 Hold dout_ready low 10 cycles in HOLD, toggle mux_y and start -> dout, dout_valid, selects unchanged; scan_count increments once when ready rises.
REQ-028 abort at the cycle SAMPLE idx=2 is active -> next cycle IDLE, busy=0, dout=0, selects 00; start+abort together in IDLE -> remains IDLE.
REQ-029 rst asserted mid-SETTLE with scan_count=5 -> all outputs 0, scan_count 0; new start afterwards completes normally.
REQ-030 scan_count at 255, completed handshake -> scan_count wraps to 0.
